// File: rtl/mem_io_ctrl_pkg.sv
// Shared types and default build constants for the memory/IO controller.
package mem_io_pkg;

  localparam int DW_DEFAULT          = 16;
  localparam int AW_DEFAULT          = 16;
  localparam int WAIT_STATES_DEFAULT = 2;
  localparam int NUM_HEX_DEFAULT     = 4;

  typedef enum logic [2:0] {
    IDLE,
    SRAM_RD,
    SRAM_WR,
    IO,
    DONE
  } state_e;

endpackage

// File: rtl/mem_io_ctrl_if.sv
// CPU-side request/response handshake of the memory/IO controller.
interface mem_io_cpu_if
  import mem_io_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int AW = AW_DEFAULT
) ();

  logic          Req;
  logic          Req_WE;
  logic [AW-1:0] Req_Addr;
  logic [DW-1:0] Req_WData;
  logic          Ready;
  logic          Ack;
  logic [DW-1:0] RData;

  modport master (
    output Req, Req_WE, Req_Addr, Req_WData,
    input  Ready, Ack, RData
  );

  modport slave (
    input  Req, Req_WE, Req_Addr, Req_WData,
    output Ready, Ack, RData
  );

endinterface

// File: rtl/mem_io_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous board inputs.
module sync2 #(
  parameter int WIDTH = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/mem_io_ctrl.sv
// Single-outstanding CPU access controller: SRAM with fixed wait states plus
// one memory-mapped switch/hex register.
module mem_io_ctrl
  import mem_io_pkg::*;
#(
  parameter int          DW          = DW_DEFAULT,
  parameter int          AW          = AW_DEFAULT,
  parameter int          WAIT_STATES = WAIT_STATES_DEFAULT,
  parameter int          NUM_HEX     = NUM_HEX_DEFAULT,
  parameter logic [AW-1:0] IO_ADDR   = '1
) (
  input  logic               Clk,
  input  logic               Reset,
  mem_io_cpu_if.slave        cpu,
  output logic [AW-1:0]      SRAM_Addr,
  output logic [DW-1:0]      SRAM_DOut,
  input  logic [DW-1:0]      SRAM_DIn,
  output logic               OE_n,
  output logic               WE_n,
  input  logic [9:0]         Switches,
  output logic [4*NUM_HEX-1:0] Hex
);

  if (4*NUM_HEX > DW) begin : gen_bad_hex
    $error("mem_io_ctrl: 4*NUM_HEX must not exceed DW");
  end
  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : gen_bad_wait
    $error("mem_io_ctrl: WAIT_STATES must be in 0..15");
  end

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        wdata_q, wdata_d;
  logic [DW-1:0]        rdata_q, rdata_d;
  logic [4*NUM_HEX-1:0] hex_q, hex_d;
  logic [9:0]           swSync;

  sync2 #(.WIDTH(10)) u_sync2 (
    .Clk   (Clk),
    .Reset (Reset),
    .d_i   (Switches),
    .q_o   (swSync)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      hex_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      hex_q   <= hex_d;
    end
  end

  // The counter is loaded on accept and only decremented while nonzero, so a
  // zero-wait build spends exactly one cycle in the strobe state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    hex_d     = hex_q;
    cpu.Ready = 1'b0;
    cpu.Ack   = 1'b0;
    OE_n      = 1'b1;
    WE_n      = 1'b1;
    case (state_q)
      IDLE: begin
        cpu.Ready = 1'b1;
        if (cpu.Req) begin
          we_d    = cpu.Req_WE;
          addr_d  = cpu.Req_Addr;
          wdata_d = cpu.Req_WData;
          cnt_d   = 4'(WAIT_STATES);
          if (cpu.Req_Addr == IO_ADDR) state_d = IO;
          else if (cpu.Req_WE)         state_d = SRAM_WR;
          else                         state_d = SRAM_RD;
        end
      end
      SRAM_RD: begin
        OE_n = 1'b0;
        if (cnt_q == 4'd0) begin
          rdata_d = SRAM_DIn;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      SRAM_WR: begin
        WE_n = 1'b0;
        if (cnt_q == 4'd0) state_d = DONE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      IO: begin
        if (we_q) hex_d   = wdata_q[4*NUM_HEX-1:0];
        else      rdata_d = DW'(swSync);
        state_d = DONE;
      end
      DONE: begin
        cpu.Ack = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu.RData = rdata_q;
  assign SRAM_Addr = addr_q;
  assign SRAM_DOut = wdata_q;
  assign Hex       = hex_q;

endmodule

// File: tb/tb_mem_io_ctrl.sv
// Directed self-checking bench for mem_io_ctrl (default build and a zero-wait build).
module tb_mem_io_ctrl;
  import mem_io_pkg::*;

  logic        Clk;
  logic        Reset;
  logic [15:0] sramAddr0, sramDOut0, sramDIn0, sramAddr1, sramDOut1, sramDIn1;
  logic        oeN0, weN0, oeN1, weN1;
  logic [9:0]  switches;
  logic [15:0] hex0, hex1;

  int testsRun  = 0;
  int failCount = 0;

  mem_io_cpu_if #(.DW(16), .AW(16)) cpu0 ();
  mem_io_cpu_if #(.DW(16), .AW(16)) cpu1 ();

  mem_io_ctrl dut0 (
    .Clk(Clk), .Reset(Reset), .cpu(cpu0.slave),
    .SRAM_Addr(sramAddr0), .SRAM_DOut(sramDOut0), .SRAM_DIn(sramDIn0),
    .OE_n(oeN0), .WE_n(weN0), .Switches(switches), .Hex(hex0)
  );

  mem_io_ctrl #(.WAIT_STATES(0)) dut1 (
    .Clk(Clk), .Reset(Reset), .cpu(cpu1.slave),
    .SRAM_Addr(sramAddr1), .SRAM_DOut(sramDOut1), .SRAM_DIn(sramDIn1),
    .OE_n(oeN1), .WE_n(weN1), .Switches(switches), .Hex(hex1)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Starts at a negedge with the DUT idle; cycle 0 is the cycle Req is presented.
  task automatic applyStimulus(input bit sel, input bit we, input logic [15:0] addr,
                               input logic [15:0] data, input int window, input bit holdReq,
                               output int lat, output int ackCnt, output int oeLow,
                               output int weLow, output int overlap, output int busBad);
    logic ackS, oeS, weS;
    logic [15:0] aS, dS;
    lat = -1; ackCnt = 0; oeLow = 0; weLow = 0; overlap = 0; busBad = 0;
    if (sel) begin
      cpu1.Req = 1'b1; cpu1.Req_WE = we; cpu1.Req_Addr = addr; cpu1.Req_WData = data;
    end else begin
      cpu0.Req = 1'b1; cpu0.Req_WE = we; cpu0.Req_Addr = addr; cpu0.Req_WData = data;
    end
    for (int c = 0; c < window; c++) begin
      ackS = sel ? cpu1.Ack : cpu0.Ack;
      oeS  = sel ? oeN1 : oeN0;
      weS  = sel ? weN1 : weN0;
      aS   = sel ? sramAddr1 : sramAddr0;
      dS   = sel ? sramDOut1 : sramDOut0;
      if (ackS) begin
        ackCnt++;
        if (lat < 0) lat = c;
      end
      if (!oeS) oeLow++;
      if (!weS) weLow++;
      if (!oeS && !weS) overlap++;
      if ((!oeS || !weS) && aS !== addr) busBad++;
      if (!weS && dS !== data) busBad++;
      @(posedge Clk);
      #1;
      if (c == 0 && !holdReq) begin
        if (sel) cpu1.Req = 1'b0; else cpu0.Req = 1'b0;
      end
      @(negedge Clk);
    end
    if (sel) cpu1.Req = 1'b0; else cpu0.Req = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if ((sel ? cpu1.Ready : cpu0.Ready) === 1'b1) break;
      @(negedge Clk);
    end
    checkOutput("drainReady", {31'd0, sel ? cpu1.Ready : cpu0.Ready}, 32'd1);
  endtask

  int lat, ackCnt, oeLow, weLow, overlap, busBad;

  initial begin
    Reset = 1'b0;
    switches = 10'h000;
    sramDIn0 = 16'h0000; sramDIn1 = 16'h0000;
    cpu0.Req = 1'b0; cpu0.Req_WE = 1'b0; cpu0.Req_Addr = '0; cpu0.Req_WData = '0;
    cpu1.Req = 1'b0; cpu1.Req_WE = 1'b0; cpu1.Req_Addr = '0; cpu1.Req_WData = '0;
    #3;
    checkOutput("rstReady", {31'd0, cpu0.Ready}, 32'd1);
    checkOutput("rstAck",   {31'd0, cpu0.Ack},   32'd0);
    checkOutput("rstOeN",   {31'd0, oeN0},       32'd1);
    checkOutput("rstWeN",   {31'd0, weN0},       32'd1);
    checkOutput("rstRData", {16'd0, cpu0.RData}, 32'd0);
    checkOutput("rstHex",   {16'd0, hex0},       32'd0);
    checkOutput("rstAddr",  {16'd0, sramAddr0},  32'd0);
    checkOutput("rstDOut",  {16'd0, sramDOut0},  32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);

    sramDIn0 = 16'h1234;
    applyStimulus(1'b0, 1'b0, 16'h0010, 16'h0000, 7, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("rdLatency", lat,    32'd4);
    checkOutput("rdAckCnt",  ackCnt, 32'd1);
    checkOutput("rdOeLow",   oeLow,  32'd3);
    checkOutput("rdWeLow",   weLow,  32'd0);
    checkOutput("rdBus",     busBad, 32'd0);
    checkOutput("rdRData",   {16'd0, cpu0.RData}, 32'h1234);

    sramDIn0 = 16'hDEAD;
    applyStimulus(1'b0, 1'b1, 16'h0020, 16'hBEEF, 7, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("wrLatency", lat,     32'd4);
    checkOutput("wrAckCnt",  ackCnt,  32'd1);
    checkOutput("wrWeLow",   weLow,   32'd3);
    checkOutput("wrOeLow",   oeLow,   32'd0);
    checkOutput("wrOverlap", overlap, 32'd0);
    checkOutput("wrBus",     busBad,  32'd0);
    checkOutput("wrRDataKept", {16'd0, cpu0.RData}, 32'h1234);

    switches = 10'h2A5;
    applyStimulus(1'b0, 1'b1, 16'hFFFF, 16'hCAFE, 5, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("ioWrLatency", lat,   32'd2);
    checkOutput("ioWrStrobes", oeLow + weLow, 32'd0);
    checkOutput("ioWrHex",     {16'd0, hex0}, 32'hCAFE);
    applyStimulus(1'b0, 1'b0, 16'hFFFF, 16'h0000, 5, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("ioRdLatency", lat,    32'd2);
    checkOutput("ioRdAckCnt",  ackCnt, 32'd1);
    checkOutput("ioRdStrobes", oeLow + weLow, 32'd0);
    checkOutput("ioRdRData",   {16'd0, cpu0.RData}, 32'h02A5);

    sramDIn0 = 16'h7777;
    applyStimulus(1'b0, 1'b0, 16'h0011, 16'h0000, 12, 1'b1, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("holdFirstAck", lat,    32'd4);
    checkOutput("holdAckCnt",   ackCnt, 32'd2);
    checkOutput("holdOeLow",    oeLow,  32'd7);
    checkOutput("holdRData",    {16'd0, cpu0.RData}, 32'h7777);

    cpu0.Req = 1'b1; cpu0.Req_WE = 1'b1; cpu0.Req_Addr = 16'h0040; cpu0.Req_WData = 16'h1111;
    @(posedge Clk);
    #1 cpu0.Req = 1'b0;
    @(negedge Clk);
    checkOutput("abortWeLowBefore", {31'd0, weN0}, 32'd0);
    @(posedge Clk);
    #2 Reset = 1'b0;
    #1;
    checkOutput("abortWeN",   {31'd0, weN0},       32'd1);
    checkOutput("abortAck",   {31'd0, cpu0.Ack},   32'd0);
    checkOutput("abortReady", {31'd0, cpu0.Ready}, 32'd1);
    checkOutput("abortHex",   {16'd0, hex0},       32'd0);
    checkOutput("abortRData", {16'd0, cpu0.RData}, 32'd0);
    checkOutput("abortAddr",  {16'd0, sramAddr0},  32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    ackCnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (cpu0.Ack) ackCnt++;
      @(negedge Clk);
    end
    checkOutput("abortNoAck", ackCnt, 32'd0);
    sramDIn0 = 16'h5A5A;
    applyStimulus(1'b0, 1'b0, 16'h0050, 16'h0000, 7, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("postRstLatency", lat,    32'd4);
    checkOutput("postRstAckCnt",  ackCnt, 32'd1);
    checkOutput("postRstRData",   {16'd0, cpu0.RData}, 32'h5A5A);

    sramDIn1 = 16'h0F0F;
    applyStimulus(1'b1, 1'b0, 16'h0030, 16'h0000, 5, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("w0Latency", lat,    32'd2);
    checkOutput("w0OeLow",   oeLow,  32'd1);
    checkOutput("w0AckCnt",  ackCnt, 32'd1);
    checkOutput("w0RData",   {16'd0, cpu1.RData}, 32'h0F0F);
    applyStimulus(1'b1, 1'b1, 16'h0031, 16'hA5A5, 5, 1'b0, lat, ackCnt, oeLow, weLow, overlap, busBad);
    checkOutput("w0WrWeLow", weLow,  32'd1);
    checkOutput("w0WrBus",   busBad, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule

// File: doc/mem_io_ctrl.md
MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

Interface
REQ-001 The block SHALL have parameter DW, default 16, meaning data width in bits.
REQ-002 The block SHALL have parameter AW, default 16, meaning address width in bits.
REQ-003 The block SHALL have parameter WAIT_STATES, default 2, meaning extra SRAM cycles per access (legal range 0..15).
REQ-004 The block SHALL have parameter NUM_HEX, default 4, meaning hex digits held by the IO register (4*NUM_HEX <= DW).
REQ-005 The block SHALL have parameter IO_ADDR, default all-ones, meaning the memory-mapped switch/hex address.
REQ-006 The block SHALL have ports: Clk  in  1  sole clock, rising edge; Reset  in  1  asynchronous, active-low reset.
REQ-007 The block SHALL have ports: Req  in  1  CPU access request; Req_WE  in  1  1=write, 0=read; Req_Addr  in  AW  address; Req_WData  in  DW  write data.
REQ-008 The block SHALL have ports: Ready  out  1  idle, request acceptable; Ack  out  1  one-cycle completion pulse; RData  out  DW  read result.
REQ-009 The block SHALL have ports: SRAM_Addr  out  AW; SRAM_DOut  out  DW  data to SRAM; SRAM_DIn  in  DW  data from SRAM; OE_n  out  1; WE_n  out  1  (both active-low).
REQ-010 The block SHALL have ports: Switches  in  10  board switches; Hex  out  4*NUM_HEX  hex digit nibbles, digit 0 in bits [3:0].

Function
REQ-011 FSM states SHALL be IDLE, SRAM_RD, SRAM_WR, IO, DONE; Ready=1 only in IDLE.
REQ-012 In IDLE with Req=1 at a rising edge, the block SHALL latch Req_WE/Req_Addr/Req_WData and go to IO if address==IO_ADDR, else to SRAM_RD (Req_WE=0) or SRAM_WR (Req_WE=1).
REQ-013 Req while not in IDLE SHALL be ignored; no queuing.
REQ-014 SRAM_RD SHALL hold OE_n=0, WE_n=1, SRAM_Addr=latched address for exactly WAIT_STATES+1 cycles via a 4-bit down-counter, capture SRAM_DIn into RData on the final cycle's edge, then go to DONE.
REQ-015 SRAM_WR SHALL hold WE_n=0, OE_n=1, SRAM_Addr and SRAM_DOut stable for exactly WAIT_STATES+1 cycles, then go to DONE; RData unchanged.
REQ-016 IO SHALL last one cycle: a read loads RData with zero-extended synchronised Switches; a write loads Hex with latched data bits [4*NUM_HEX-1:0]; then go to DONE.
REQ-017 DONE SHALL assert Ack=1 for exactly one cycle and return to IDLE; Req in DONE SHALL be ignored.
REQ-018 Latency accept-edge to Ack-high SHALL be WAIT_STATES+2 cycles for SRAM and 2 cycles for IO.
REQ-019 OE_n and WE_n SHALL never be low simultaneously, and both SHALL be 1 outside SRAM_RD/SRAM_WR.
REQ-020 SRAM accesses to IO_ADDR SHALL never occur (IO decode wins).
REQ-021 WAIT_STATES=0 SHALL give one-cycle strobes with no counter wrap; the counter SHALL never underflow.
REQ-022 Switches SHALL pass a two-flop synchroniser before use.

Reset
REQ-023 Reset=0 SHALL immediately force IDLE, Ready=1, Ack=0, OE_n=1, WE_n=1, RData=0, Hex=0, SRAM_Addr=0, SRAM_DOut=0, counter=0, synchroniser=0.
REQ-024 Reset asserted mid-access SHALL abort the access with no Ack; after release the first Req is accepted normally.

Structure
REQ-025 Package mem_io_pkg SHALL hold the state enum and the default parameter constants.
REQ-026 The two-flop synchroniser SHALL be the sub-module sync2, parametrised by width.
REQ-027 Elaboration SHALL fail if 4*NUM_HEX > DW or WAIT_STATES > 15.

Verification
REQ-028 Read, WAIT_STATES=2, addr 0x0010, SRAM_DIn=0x1234 -> OE_n low 3 cycles, Ack 4 cycles after accept, RData=0x1234.
REQ-029 Write, addr 0x0020, data 0xBEEF -> WE_n low 3 cycles with SRAM_DOut=0xBEEF, SRAM_Addr=0x0020, OE_n=1 throughout, single Ack.
REQ-030 IO write 0xCAFE to 0xFFFF, then IO read with Switches=0x2A5 -> Hex=0xCAFE, no SRAM strobe, RData=0x02A5 (after synchroniser settle), each Ack at 2 cycles.
REQ-031 Req held high across an SRAM read -> exactly one access per IDLE visit, back-to-back accesses separated by the DONE cycle, no extra Ack.
REQ-032 Reset=0 during second wait cycle of a write -> WE_n=1 same cycle, no Ack, Hex=0; next read completes normally.
REQ-033 WAIT_STATES=0 build: read -> OE_n low 1 cycle, Ack 2 cycles after accept.
